hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler.sv | 120 ++++++++++++
 tb/tb_hazard_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scheduler : RAW hazard detection over a shadow EXE/MEM pipeline,
//                    with branch flush, stall/flush FSM and event counters.
// Revision 1.0
// ---------------------------------------------------------------------------
module hazard_scheduler #(
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             isSrc2,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [4:0]       id_dest,
    input  logic             br_taken,
    output logic             freez,
    output logic             flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        SQUASH = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     r_state;
    state_t     w_state_nx;
    logic       r_exe_wb, r_exe_rd, r_mem_wb, r_mem_rd;
    logic [4:0] r_exe_dest, r_mem_dest;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic       w_exe_hit, w_mem_hit, w_hazard;

    // Register 0 is hard-wired, so a slot writing it never matches.
    always_comb begin
        w_exe_hit = r_exe_wb && (r_exe_dest != 5'd0) &&
                    ((r_exe_dest == src1) || (isSrc2 && (r_exe_dest == src2)));
        w_mem_hit = r_mem_wb && (r_mem_dest != 5'd0) &&
                    ((r_mem_dest == src1) || (isSrc2 && (r_mem_dest == src2)));
        if (FWD_EN != 0) begin
            w_hazard = w_exe_hit && r_exe_rd;
        end else begin
            w_hazard = w_exe_hit || w_mem_hit;
        end
    end

    assign flush = !rst && br_taken;
    assign freez = !rst && w_hazard && !br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_wb   <= 1'b0;
            r_exe_rd   <= 1'b0;
            r_exe_dest <= 5'd0;
            r_mem_wb   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_dest <= 5'd0;
        end else begin
            r_mem_wb   <= r_exe_wb;
            r_mem_rd   <= r_exe_rd;
            r_mem_dest <= r_exe_dest;
            if (freez || flush) begin
                r_exe_wb   <= 1'b0;
                r_exe_rd   <= 1'b0;
                r_exe_dest <= 5'd0;
            end else begin
                r_exe_wb   <= id_wb_en;
                r_exe_rd   <= id_mem_read;
                r_exe_dest <= id_dest;
            end
        end
    end

    always_comb begin
        w_state_nx = RUN;
        if (flush) begin
            w_state_nx = SQUASH;
        end else if (freez) begin
            w_state_nx = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (freez && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (flush && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_scheduler : drives a no-forwarding and a forwarding instance with
//                       shared stimulus and compares against a slot model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_hazard_scheduler;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       wb;
        logic       rd;
        logic [4:0] dest;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] src1, src2, id_dest;
    logic       isSrc2, id_wb_en, id_mem_read, br_taken;

    logic          freez_o [2];
    logic          flush_o [2];
    logic [1:0]    state_o [2];
    logic [CW-1:0] scnt_o  [2];
    logic [CW-1:0] fcnt_o  [2];

    hazard_scheduler #(.FWD_EN(0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .isSrc2(isSrc2),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .br_taken(br_taken), .freez(freez_o[0]), .flush(flush_o[0]),
        .state(state_o[0]), .stall_cnt(scnt_o[0]), .flush_cnt(fcnt_o[0])
    );

    hazard_scheduler #(.FWD_EN(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .isSrc2(isSrc2),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .br_taken(br_taken), .freez(freez_o[1]), .flush(flush_o[1]),
        .state(state_o[1]), .stall_cnt(scnt_o[1]), .flush_cnt(fcnt_o[1])
    );

    // Reference: instance 0 = no forwarding, instance 1 = EXE forwarding.
    slot_t m_exe [2];
    slot_t m_mem [2];
    int    m_state [2];
    int    m_scnt  [2];
    int    m_fcnt  [2];
    bit    m_freez [2];
    bit    m_flush [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads(input slot_t s);
        return s.wb && (s.dest != 5'd0) &&
               ((s.dest == src1) || (isSrc2 && (s.dest == src2)));
    endfunction

    task automatic model_comb();
        bit hz;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) hz = reads(m_exe[k]) || reads(m_mem[k]);
            else        hz = reads(m_exe[k]) && m_exe[k].rd;
            m_flush[k] = !rst && br_taken;
            m_freez[k] = !rst && hz && !br_taken;
        end
    endtask

    task automatic model_clk();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_exe[k] = '0; m_mem[k] = '0;
                m_state[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
            end else begin
                m_mem[k] = m_exe[k];
                m_exe[k] = (m_freez[k] || m_flush[k]) ? slot_t'(0)
                         : slot_t'({id_wb_en, id_mem_read, id_dest});
                m_state[k] = m_flush[k] ? 2 : (m_freez[k] ? 1 : 0);
                if (m_freez[k] && m_scnt[k] < CMAX) m_scnt[k]++;
                if (m_flush[k] && m_fcnt[k] < CMAX) m_fcnt[k]++;
            end
        end
    endtask

    // Entered just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        model_comb();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("freez%0d", k), int'(freez_o[k]), int'(m_freez[k]));
            chk($sformatf("flush%0d", k), int'(flush_o[k]), int'(m_flush[k]));
            chk($sformatf("state%0d", k), int'(state_o[k]), m_state[k]);
            chk($sformatf("stall_cnt%0d", k), int'(scnt_o[k]), m_scnt[k]);
            chk($sformatf("flush_cnt%0d", k), int'(fcnt_o[k]), m_fcnt[k]);
        end
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic set_id(input int s1, input int s2, input bit is2, input bit wb,
                          input bit rd, input int dst, input bit br);
        src1 = 5'(s1); src2 = 5'(s2); isSrc2 = is2;
        id_wb_en = wb; id_mem_read = rd; id_dest = 5'(dst); br_taken = br;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_exe[k] = '0; m_mem[k] = '0; m_state[k] = 0;
            m_scnt[k] = 0; m_fcnt[k] = 0; m_freez[k] = 0; m_flush[k] = 0;
        end
        rst = 1'b1;
        set_id(3, 3, 1, 1, 1, 3, 1);
        @(negedge clk);
        #1;
        chk("rst_freez", int'(freez_o[0]), 0);
        chk("rst_flush", int'(flush_o[0]), 0);
        cycle();
        chk("rst_state", int'(state_o[0]), 0);
        chk("rst_stall_cnt", int'(scnt_o[0]), 0);
        chk("rst_flush_cnt", int'(fcnt_o[1]), 0);
        rst = 1'b0;

        // ADD r3 ; SUB r3 without forwarding: two stall cycles
        do_reset();
        set_id(0, 0, 0, 1, 0, 3, 0); cycle();
        set_id(3, 0, 0, 1, 0, 4, 0);
        #1 chk("raw_exe_freez", int'(freez_o[0]), 1);
        chk("raw_fwd_nostall", int'(freez_o[1]), 0);
        cycle();
        chk("raw_state_stall", int'(state_o[0]), 1);
        #1 chk("raw_mem_freez", int'(freez_o[0]), 1);
        cycle();
        #1 chk("raw_release", int'(freez_o[0]), 0);
        chk("raw_stall_cnt", int'(scnt_o[0]), 2);
        cycle();

        // LD r5 ; ADD src2=r5: one-cycle load-use stall with forwarding
        do_reset();
        set_id(0, 0, 0, 1, 1, 5, 0); cycle();
        set_id(0, 5, 1, 1, 0, 6, 0);
        #1 chk("ldu_freez", int'(freez_o[1]), 1);
        cycle();
        #1 chk("ldu_release", int'(freez_o[1]), 0);
        chk("ldu_stall_cnt", int'(scnt_o[1]), 1);
        cycle();
        do_reset();
        set_id(0, 0, 0, 1, 1, 5, 0); cycle();
        set_id(0, 5, 0, 1, 0, 6, 0);
        #1 chk("ldu_nosrc2_fwd", int'(freez_o[1]), 0);
        chk("ldu_nosrc2_nofwd", int'(freez_o[0]), 0);
        cycle();

        // r0 never hazards
        do_reset();
        set_id(0, 0, 0, 1, 1, 0, 0); cycle();
        set_id(0, 0, 1, 1, 0, 0, 0);
        #1 chk("r0_nofwd", int'(freez_o[0]), 0);
        chk("r0_fwd", int'(freez_o[1]), 0);
        cycle(); cycle();

        // branch taken over a hazard: flush wins, EXE slot bubbled
        do_reset();
        set_id(0, 0, 0, 1, 1, 5, 0); cycle();
        set_id(5, 0, 0, 1, 0, 6, 1);
        #1 chk("br_flush", int'(flush_o[1]), 1);
        chk("br_freez", int'(freez_o[1]), 0);
        chk("br_freez0", int'(freez_o[0]), 0);
        cycle();
        chk("br_state", int'(state_o[0]), 2);
        chk("br_flush_cnt", int'(fcnt_o[0]), 1);
        set_id(5, 0, 0, 1, 0, 6, 0);
        #1 chk("br_exe_bubble", int'(freez_o[1]), 0);
        cycle();

        // reset during the second stall cycle
        do_reset();
        set_id(0, 0, 0, 1, 0, 3, 0); cycle();
        set_id(3, 0, 0, 1, 0, 4, 0); cycle();
        rst = 1'b1;
        #1 chk("rstmid_freez", int'(freez_o[0]), 0);
        chk("rstmid_flush", int'(flush_o[0]), 0);
        cycle();
        rst = 1'b0;
        #1 chk("rstmid_cnt", int'(scnt_o[0]), 0);
        chk("rstmid_state", int'(state_o[0]), 0);
        chk("rstmid_proceed", int'(freez_o[0]), 0);
        cycle();

        // counter saturation: 140 stalls on instance 0, 70 on instance 1
        do_reset();
        for (int i = 0; i < 70; i++) begin
            set_id(0, 0, 0, 1, 1, 3, 0); cycle();
            set_id(3, 0, 0, 1, 0, 7, 0); cycle(); cycle();
        end
        chk("sat_nofwd", int'(scnt_o[0]), CMAX);
        chk("sat_fwd", int'(scnt_o[1]), CMAX);

        // randomized traffic; ID is held while the no-forwarding model stalls
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!m_freez[0]) begin
                set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                       1'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
            end
            br_taken = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
